// File: rtl/alu_cc_pkg.sv
// -----------------------------------------------------------------------------
// alu_cc_pkg
// Shared definitions for the ALU result / condition-code unit:
//   - branch condition code encodings COND_EQ .. COND_NV
//   - branch FSM state encoding BR_IDLE / BR_WAIT / BR_RESP
//   - the {z,v,n} flags struct and its width
// Build option (consumed in alu_cc_unit): ALU_CC_SIGNED_COND_EN
// -----------------------------------------------------------------------------
package alu_cc_pkg;

    localparam int DATA_W  = 16;
    localparam int FLAGS_W = 3;

    // Branch condition encodings.
    localparam logic [2:0] COND_EQ = 3'b000;
    localparam logic [2:0] COND_NE = 3'b001;
    localparam logic [2:0] COND_LT = 3'b010;
    localparam logic [2:0] COND_GE = 3'b011;
    localparam logic [2:0] COND_MI = 3'b100;
    localparam logic [2:0] COND_VS = 3'b101;
    localparam logic [2:0] COND_AL = 3'b110;
    localparam logic [2:0] COND_NV = 3'b111;

    typedef enum logic [1:0] {
        BR_IDLE = 2'b00,
        BR_WAIT = 2'b01,
        BR_RESP = 2'b10
    } br_state_t;

    // Packed in {z,v,n} order so the struct maps directly onto cc_flags.
    typedef struct packed {
        logic z;
        logic v;
        logic n;
    } flags_t;

endpackage

// File: rtl/alu_cc_fifo.sv
// -----------------------------------------------------------------------------
// alu_cc_fifo
// Two-entry in-order result buffer. Each entry holds result, destination
// register, {z,v,n} flags and the setcc bit. Also tracks how many buffered
// entries will update the condition codes when they retire (pending_o).
//
// Ports:
//   clk, rst_n              clock, async active-low reset
//   push_valid_i/ready_o    producer handshake (ready is registered-state only)
//   push_data_i/rd_i/flags_i/setcc_i   entry fields
//   pop_valid_o/ready_i     consumer handshake on the head entry
//   head_data_o/rd_o/flags_o/setcc_o   head entry fields
//   pop_o                   a pop happens at the next rising edge
//   pending_o               buffered entries with setcc=1
// -----------------------------------------------------------------------------
module alu_cc_fifo
    import alu_cc_pkg::*;
#(
    parameter int DEPTH = 2,   // only 2 is supported (1-bit pointers)
    parameter int RD_W  = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push_valid_i,
    output logic              push_ready_o,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic [RD_W-1:0]   push_rd_i,
    input  logic [2:0]        push_flags_i,
    input  logic              push_setcc_i,
    output logic              pop_valid_o,
    input  logic              pop_ready_i,
    output logic [DATA_W-1:0] head_data_o,
    output logic [RD_W-1:0]   head_rd_o,
    output logic [2:0]        head_flags_o,
    output logic              head_setcc_o,
    output logic              pop_o,
    output logic [1:0]        pending_o
);

    localparam logic [1:0] FULL_CNT = 2'(DEPTH);

    logic [DATA_W-1:0] data_q  [2];
    logic [RD_W-1:0]   rd_q    [2];
    logic [2:0]        flags_q [2];
    logic              setcc_q [2];

    logic       head_q, head_d;
    logic       tail_q, tail_d;
    logic [1:0] count_q, count_d;
    logic [1:0] pending_q, pending_d;
    logic       push;

    // Ready depends only on registered count, so a pop in the same cycle
    // never frees a slot for a push (no wb_ready -> in_ready path).
    assign push_ready_o = (count_q != FULL_CNT);
    assign pop_valid_o  = (count_q != 2'd0);
    assign push         = push_valid_i && push_ready_o;
    assign pop_o        = pop_valid_o && pop_ready_i;

    assign head_data_o  = data_q[head_q];
    assign head_rd_o    = rd_q[head_q];
    assign head_flags_o = flags_q[head_q];
    assign head_setcc_o = setcc_q[head_q];
    assign pending_o    = pending_q;

    // NOTE: every variable gets a default at the top of an always_comb so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        pending_d = pending_q;
        if (push) begin
            tail_d = ~tail_q;
            if (push_setcc_i) pending_d = pending_d + 2'd1;
        end
        if (pop_o) begin
            head_d = ~head_q;
            if (setcc_q[head_q]) pending_d = pending_d - 2'd1;
        end
        unique case ({push, pop_o})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q    <= 1'b0;
            tail_q    <= 1'b0;
            count_q   <= 2'd0;
            pending_q <= 2'd0;
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            pending_q <= pending_d;
        end
    end

    // NOTE: the storage is reset because the head entry drives wb_data/wb_rd
    // directly and those outputs must read zero out of reset; at two entries
    // the reset cost is negligible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                data_q[i]  <= '0;
                rd_q[i]    <= '0;
                flags_q[i] <= '0;
                setcc_q[i] <= 1'b0;
            end
        end else if (push) begin
            data_q[tail_q]  <= push_data_i;
            rd_q[tail_q]    <= push_rd_i;
            flags_q[tail_q] <= push_flags_i;
            setcc_q[tail_q] <= push_setcc_i;
        end
    end

endmodule

// File: rtl/alu_cc_unit.sv
// -----------------------------------------------------------------------------
// alu_cc_unit
// Result-side consumer for the 16-bit ALU. Buffers up to two results,
// retires them in order to register-file writeback, commits flags of setcc
// results into the condition-code register on retire, and answers branch
// queries once no buffered flag-setting result remains.
//
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   in_valid/in_ready                  ALU result handshake
//   in_result, in_z/in_v/in_n, in_rd, in_setcc   result fields
//   wb_valid/wb_ready, wb_data, wb_rd  writeback of the head entry
//   br_req, br_cond                    branch query (held until br_ack)
//   br_ack, br_taken                   one-cycle response, held result
//   cc_flags                           committed {z,v,n}
//
// Build option: ALU_CC_SIGNED_COND_EN -- LT/GE use n^v (signed compare);
// otherwise LT/GE use n alone.
// -----------------------------------------------------------------------------
module alu_cc_unit
    import alu_cc_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int RD_W  = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [15:0]     in_result,
    input  logic            in_z,
    input  logic            in_v,
    input  logic            in_n,
    input  logic [RD_W-1:0] in_rd,
    input  logic            in_setcc,
    output logic            wb_valid,
    input  logic            wb_ready,
    output logic [15:0]     wb_data,
    output logic [RD_W-1:0] wb_rd,
    input  logic            br_req,
    input  logic [2:0]      br_cond,
    output logic            br_ack,
    output logic            br_taken,
    output logic [2:0]      cc_flags
);

    logic       pop;
    logic [2:0] head_flags;
    logic       head_setcc;
    logic [1:0] pending;

    flags_t     cc_q, cc_d;
    br_state_t  state_q, state_d;
    logic       taken_q, taken_d;

    alu_cc_fifo #(
        .DEPTH (DEPTH),
        .RD_W  (RD_W)
    ) u_fifo (
        .clk          (clk),
        .rst_n        (rst_n),
        .push_valid_i (in_valid),
        .push_ready_o (in_ready),
        .push_data_i  (in_result),
        .push_rd_i    (in_rd),
        .push_flags_i ({in_z, in_v, in_n}),
        .push_setcc_i (in_setcc),
        .pop_valid_o  (wb_valid),
        .pop_ready_i  (wb_ready),
        .head_data_o  (wb_data),
        .head_rd_o    (wb_rd),
        .head_flags_o (head_flags),
        .head_setcc_o (head_setcc),
        .pop_o        (pop),
        .pending_o    (pending)
    );

    function automatic logic eval_cond(input logic [2:0] cond, input flags_t f);
        logic r;
        r = 1'b0;
        unique case (cond)
            COND_EQ: r = f.z;
            COND_NE: r = ~f.z;
`ifdef ALU_CC_SIGNED_COND_EN
            COND_LT: r = f.n ^ f.v;
            COND_GE: r = ~(f.n ^ f.v);
`else
            COND_LT: r = f.n;
            COND_GE: r = ~f.n;
`endif
            COND_MI: r = f.n;
            COND_VS: r = f.v;
            COND_AL: r = 1'b1;
            COND_NV: r = 1'b0;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    // Flags commit at the same edge the setcc entry retires.
    always_comb begin
        cc_d = cc_q;
        if (pop && head_setcc) cc_d = flags_t'(head_flags);
    end

    // Branch FSM. pending is registered, so a push in the WAIT cycle that
    // resolves the query is not counted and lands after the branch.
    always_comb begin
        state_d = state_q;
        taken_d = taken_q;
        unique case (state_q)
            BR_IDLE: if (br_req) state_d = BR_WAIT;
            BR_WAIT: begin
                if (pending == 2'd0) begin
                    taken_d = eval_cond(br_cond, cc_q);
                    state_d = BR_RESP;
                end
            end
            BR_RESP: state_d = BR_IDLE;
            default: state_d = BR_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cc_q    <= '0;
            state_q <= BR_IDLE;
            taken_q <= 1'b0;
        end else begin
            cc_q    <= cc_d;
            state_q <= state_d;
            taken_q <= taken_d;
        end
    end

    assign br_ack   = (state_q == BR_RESP);
    assign br_taken = taken_q;
    assign cc_flags = cc_q;

endmodule

// File: tb/tb_alu_cc_unit.sv
// -----------------------------------------------------------------------------
// tb_alu_cc_unit
// Scoreboard bench: accepted results and issued branch queries push expected
// responses into queues; a negedge monitor pops and compares whenever the
// DUT presents writeback data or a branch acknowledge.
// -----------------------------------------------------------------------------
module tb_alu_cc_unit;

    localparam int RD_W = 3;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [15:0]     in_result;
    logic            in_z, in_v, in_n;
    logic [RD_W-1:0] in_rd;
    logic            in_setcc;
    logic            wb_valid;
    logic            wb_ready;
    logic [15:0]     wb_data;
    logic [RD_W-1:0] wb_rd;
    logic            br_req;
    logic [2:0]      br_cond;
    logic            br_ack;
    logic            br_taken;
    logic [2:0]      cc_flags;

    alu_cc_unit #(.DEPTH(2), .RD_W(RD_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_result (in_result),
        .in_z      (in_z),
        .in_v      (in_v),
        .in_n      (in_n),
        .in_rd     (in_rd),
        .in_setcc  (in_setcc),
        .wb_valid  (wb_valid),
        .wb_ready  (wb_ready),
        .wb_data   (wb_data),
        .wb_rd     (wb_rd),
        .br_req    (br_req),
        .br_cond   (br_cond),
        .br_ack    (br_ack),
        .br_taken  (br_taken),
        .cc_flags  (cc_flags)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0]     data;
        logic [RD_W-1:0] rd;
        logic [2:0]      flags;   // {z,v,n}
        logic            setcc;
    } entry_t;

    typedef struct {
        logic taken;
        int   lat;      // expected edges from issue to ack, -1 = not fixed
        int   issue;
    } br_exp_t;

    entry_t  exp_q[$];
    br_exp_t br_exp_q[$];
    logic [2:0] model_cc;
    int checks   = 0;
    int failures = 0;
    int edge_cnt = 0;
    logic last_ack = 1'b0;
    int br_wait;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference condition table, {z,v,n} operand.
    function automatic logic model_eval(input logic [2:0] c, input logic [2:0] f);
        logic z, v, n;
        {z, v, n} = f;
        case (c)
            3'd0: return z;
            3'd1: return !z;
`ifdef ALU_CC_SIGNED_COND_EN
            3'd2: return (n != v);
            3'd3: return (n == v);
`else
            3'd2: return n;
            3'd3: return !n;
`endif
            3'd4: return n;
            3'd5: return v;
            3'd6: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    always @(posedge clk) edge_cnt++;

    // Monitor: state visible in this cycle vs model, then account for the
    // handshakes that will complete at the coming rising edge.
    always @(negedge clk) begin
        entry_t  e;
        br_exp_t b;
        last_ack = br_ack;
        if (rst_n) begin
            check("in_ready", in_ready, exp_q.size() != 2);
            check("wb_valid", wb_valid, exp_q.size() != 0);
            check("cc_flags", cc_flags, model_cc);
            if (br_ack) begin
                if (br_exp_q.size() == 0) begin
                    check("spurious_br_ack", br_ack, 0);
                end else begin
                    b = br_exp_q.pop_front();
                    check("br_taken", br_taken, b.taken);
                    if (b.lat >= 0) check("br_latency", edge_cnt - b.issue, b.lat);
                end
            end
            if (wb_valid && wb_ready && exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("wb_data", wb_data, e.data);
                check("wb_rd", wb_rd, e.rd);
                if (e.setcc) model_cc = e.flags;
            end
            if (in_valid && in_ready) begin
                e.data  = in_result;
                e.rd    = in_rd;
                e.flags = {in_z, in_v, in_n};
                e.setcc = in_setcc;
                exp_q.push_back(e);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic [15:0] d, input logic [RD_W-1:0] rd,
                            input logic [2:0] f, input logic sc);
        int   tries;
        logic acc;
        tries     = 0;
        in_valid  = 1'b1;
        in_result = d;
        in_rd     = rd;
        {in_z, in_v, in_n} = f;
        in_setcc  = sc;
        do begin
            @(negedge clk);
            acc = in_ready;
            tick();
            tries++;
        end while (!acc && tries < 100);
        if (!acc) check("push_timeout", acc, 1);
        in_valid = 1'b0;
    endtask

    // Expected branch result: CC after every buffered setcc entry retires.
    task automatic start_branch(input logic [2:0] c);
        br_exp_t b;
        logic [2:0] cc;
        logic has_sc;
        cc     = model_cc;
        has_sc = 1'b0;
        foreach (exp_q[j]) begin
            if (exp_q[j].setcc) begin
                cc     = exp_q[j].flags;
                has_sc = 1'b1;
            end
        end
        b.taken = model_eval(c, cc);
        b.lat   = has_sc ? -1 : 2;
        b.issue = edge_cnt;
        br_exp_q.push_back(b);
        in_valid = 1'b0;
        br_cond  = c;
        br_req   = 1'b1;
        br_wait  = 0;
    endtask

    task automatic finish_branch();
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!last_ack && n < 200);
        if (!last_ack) begin
            check("br_ack_timeout", last_ack, 1);
            br_exp_q.delete();
        end
        br_req = 1'b0;
    endtask

    task automatic drain();
        int n;
        wb_ready = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            tick();
            n++;
        end
        if (exp_q.size() != 0) check("drain_timeout", wb_valid, 0);
    endtask

    task automatic apply_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        br_req   = 1'b0;
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_wb_valid", wb_valid, 0);
        check("rst_wb_data", wb_data, 0);
        check("rst_wb_rd", wb_rd, 0);
        check("rst_br_ack", br_ack, 0);
        check("rst_br_taken", br_taken, 0);
        check("rst_cc_flags", cc_flags, 0);
        exp_q.delete();
        br_exp_q.delete();
        model_cc = 3'b000;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        tick();
    endtask

    initial begin
        rst_n = 1'b1;
        in_valid = 1'b0; in_result = '0; in_z = 1'b0; in_v = 1'b0; in_n = 1'b0;
        in_rd = '0; in_setcc = 1'b0; wb_ready = 1'b0; br_req = 1'b0; br_cond = '0;
        model_cc = 3'b000;
        #2;
        apply_reset();

        // Single pass-through of a zero result that sets CC.
        wb_ready = 1'b1;
        push_one(16'h0000, 3'd3, 3'b100, 1'b1);
        drain();
        tick();
        check("cc_after_zero", cc_flags, 3'b100);

        // Fill with wb_ready low; third push waits for the first pop.
        wb_ready = 1'b0;
        push_one(16'h1111, 3'd1, 3'b000, 1'b0);
        push_one(16'h2222, 3'd2, 3'b001, 1'b1);
        check("in_ready_full", in_ready, 0);
        fork
            push_one(16'h3333, 3'd5, 3'b010, 1'b0);
            begin
                repeat (3) tick();
                wb_ready = 1'b1;
            end
        join
        drain();

        // LT query blocked by a buffered setcc entry (n=1, v=0), then n=1, v=1.
        for (int k = 0; k < 2; k++) begin
            wb_ready = 1'b0;
            push_one(16'h8001, 3'd4, (k == 0) ? 3'b001 : 3'b011, 1'b1);
            start_branch(3'b010);
            repeat (4) tick();
            check("br_blocked", br_ack, 0);
            wb_ready = 1'b1;
            finish_branch();
            drain();
        end

        // Only setcc=0 entries buffered: EQ with z=1 resolves in 2 edges.
        push_one(16'h0000, 3'd0, 3'b100, 1'b1);
        drain();
        wb_ready = 1'b0;
        push_one(16'h1234, 3'd6, 3'b011, 1'b0);
        push_one(16'h5678, 3'd7, 3'b001, 1'b0);
        start_branch(3'b000);
        finish_branch();
        drain();

        // Randomized mix of pushes, backpressure and branch queries.
        for (int i = 0; i < 800; i++) begin
            if (br_req) begin
                if (last_ack) begin
                    br_req = 1'b0;
                end else if (++br_wait > 200) begin
                    check("rand_br_timeout", last_ack, 1);
                    br_req = 1'b0;
                    br_exp_q.delete();
                end
            end else if ($urandom_range(0, 14) == 0) begin
                start_branch(3'($urandom_range(0, 7)));
            end else begin
                in_valid  = 1'($urandom_range(0, 1));
                case ($urandom_range(0, 5))
                    0:       in_result = 16'h0000;
                    1:       in_result = 16'h8000;
                    default: in_result = 16'($urandom);
                endcase
                in_rd     = RD_W'($urandom);
                {in_z, in_v, in_n} = 3'($urandom);
                in_setcc  = 1'($urandom_range(0, 1));
            end
            wb_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        in_valid = 1'b0;
        if (br_req) finish_branch();
        drain();

        // Reset while a query waits on a full buffer: nothing may follow.
        wb_ready = 1'b0;
        push_one(16'hAAAA, 3'd1, 3'b001, 1'b1);
        push_one(16'hBBBB, 3'd2, 3'b100, 1'b1);
        start_branch(3'b100);
        repeat (3) tick();
        #2;
        apply_reset();
        wb_ready = 1'b1;
        repeat (10) tick();
        check("post_reset_cc", cc_flags, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
